// File: rtl/conv_coef_loader.sv
// conv_coef_loader
//
// Streaming coefficient loader for the 1-D causal convolution stage.
// Accepts a framed byte stream (SYNC, N, N coefficients, checksum),
// buffers the kernel in shadow registers, verifies the checksum and then
// commits taps 0..N-1 to the filter write port at one write per cycle.
// A malformed or corrupted frame never produces a write.
//
// Ports
//   clk      : rising-edge clock
//   reset    : asynchronous, active-low reset
//   s_valid  : upstream byte valid
//   s_ready  : loader can accept a byte (registered, state-derived)
//   s_data   : upstream byte
//   h_write  : coefficient write strobe (registered)
//   h_index  : tap index of the write (registered)
//   h_value  : coefficient value, two's complement (registered)
//   busy     : high whenever the FSM is not IDLE
//   done     : one-cycle pulse after a successful commit
//   error    : sticky malformed / bad-checksum flag, cleared by next SYNC

module conv_coef_loader #(
    parameter int         KERNEL_SIZE = 3,
    parameter logic [7:0] SYNC_BYTE   = 8'hA5
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       s_valid,
    output logic       s_ready,
    input  logic [7:0] s_data,
    output logic       h_write,
    output logic [3:0] h_index,
    output logic [7:0] h_value,
    output logic       busy,
    output logic       done,
    output logic       error
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_COUNT,
        ST_DATA,
        ST_CHECK,
        ST_COMMIT
    } state_t;

    state_t     r_state, w_state_next;
    logic [4:0] r_n, w_n_next;          // latched tap count N
    logic [4:0] r_cnt, w_cnt_next;      // coefficient byte counter
    logic [4:0] r_cidx, w_cidx_next;    // next commit index to present
    logic [7:0] r_sum, w_sum_next;      // running checksum, mod 256
    logic       r_ready, w_ready_next;
    logic       r_write, w_write_next;
    logic [3:0] r_index, w_index_next;
    logic [7:0] r_value, w_value_next;
    logic       r_done, w_done_next;
    logic       r_error, w_error_next;

    logic                       w_accept;
    logic [KERNEL_SIZE-1:0]     w_shadow_we;
    logic [8*KERNEL_SIZE-1:0]   w_shadow_flat;
    logic [4:0]                 w_rd_idx;
    logic [7:0]                 w_rd_data;

    // s_ready is a register, so acceptance never depends combinationally
    // on s_valid feeding back into s_ready.
    assign w_accept = s_valid && r_ready;

    // Shadow registers: one per tap, written only while collecting data.
    generate
        for (genvar gi = 0; gi < KERNEL_SIZE; gi++) begin : g_tap
            logic [7:0] r_tap;

            assign w_shadow_we[gi] = (r_state == ST_DATA) && w_accept &&
                                     (r_cnt == 5'(gi));

            always_ff @(posedge clk or negedge reset) begin
                if (!reset) begin
                    r_tap <= 8'h00;
                end else if (w_shadow_we[gi]) begin
                    r_tap <= s_data;
                end
            end

            assign w_shadow_flat[gi*8 +: 8] = r_tap;
        end
    endgenerate

    // Tap 0 is read while the checksum is being accepted so the first write
    // is presented on the cycle right after the checksum byte.
    assign w_rd_idx = (r_state == ST_COMMIT) ? r_cidx : 5'd0;

    always_comb begin
        w_rd_data = 8'h00;
        for (int k = 0; k < KERNEL_SIZE; k++) begin
            if (w_rd_idx == 5'(k)) begin
                w_rd_data = w_shadow_flat[k*8 +: 8];
            end
        end
    end

    // Next-state and registered-output logic.
    always_comb begin
        w_state_next = r_state;
        w_n_next     = r_n;
        w_cnt_next   = r_cnt;
        w_cidx_next  = r_cidx;
        w_sum_next   = r_sum;
        w_write_next = 1'b0;
        w_index_next = r_index;
        w_value_next = r_value;
        w_done_next  = 1'b0;
        w_error_next = r_error;

        case (r_state)
            ST_IDLE: begin
                if (w_accept && (s_data == SYNC_BYTE)) begin
                    w_state_next = ST_COUNT;
                    w_error_next = 1'b0;
                end
            end

            ST_COUNT: begin
                if (w_accept) begin
                    if ((s_data != 8'h00) && (s_data <= 8'(KERNEL_SIZE))) begin
                        w_n_next     = s_data[4:0];
                        w_cnt_next   = 5'd0;
                        w_sum_next   = 8'h00;
                        w_state_next = ST_DATA;
                    end else begin
                        w_error_next = 1'b1;
                        w_state_next = ST_IDLE;
                    end
                end
            end

            ST_DATA: begin
                if (w_accept) begin
                    w_sum_next = r_sum + s_data;
                    w_cnt_next = r_cnt + 5'd1;
                    if (r_cnt == (r_n - 5'd1)) begin
                        w_state_next = ST_CHECK;
                    end
                end
            end

            ST_CHECK: begin
                if (w_accept) begin
                    if (s_data == r_sum) begin
                        w_state_next = ST_COMMIT;
                        w_write_next = 1'b1;
                        w_index_next = 4'd0;
                        w_value_next = w_rd_data;
                        w_cidx_next  = 5'd1;
                    end else begin
                        w_error_next = 1'b1;
                        w_state_next = ST_IDLE;
                    end
                end
            end

            ST_COMMIT: begin
                if (r_cidx == r_n) begin
                    // All N taps have been presented; this cycle only signals completion.
                    w_done_next  = 1'b1;
                    w_state_next = ST_IDLE;
                end else begin
                    w_write_next = 1'b1;
                    w_index_next = r_cidx[3:0];
                    w_value_next = w_rd_data;
                    w_cidx_next  = r_cidx + 5'd1;
                end
            end

            default: begin
                w_state_next = ST_IDLE;
            end
        endcase

        w_ready_next = (w_state_next != ST_COMMIT);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= ST_IDLE;
            r_n     <= 5'd0;
            r_cnt   <= 5'd0;
            r_cidx  <= 5'd0;
            r_sum   <= 8'h00;
            r_ready <= 1'b0;
            r_write <= 1'b0;
            r_index <= 4'd0;
            r_value <= 8'h00;
            r_done  <= 1'b0;
            r_error <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_n     <= w_n_next;
            r_cnt   <= w_cnt_next;
            r_cidx  <= w_cidx_next;
            r_sum   <= w_sum_next;
            r_ready <= w_ready_next;
            r_write <= w_write_next;
            r_index <= w_index_next;
            r_value <= w_value_next;
            r_done  <= w_done_next;
            r_error <= w_error_next;
        end
    end

    assign s_ready = r_ready;
    assign h_write = r_write;
    assign h_index = r_index;
    assign h_value = r_value;
    assign busy    = (r_state != ST_IDLE);
    assign done    = r_done;
    assign error   = r_error;

endmodule

// File: tb/tb_conv_coef_loader.sv
// Self-checking bench for conv_coef_loader (KERNEL_SIZE = 3).
// A frame-level model predicts, per accepted byte, the timeline of writes,
// done, error, busy and s_ready; one compare process checks the DUT every
// falling edge. Literal per-frame write lists and error probes pin the model.

module tb_conv_coef_loader;

    localparam int KS = 3;

    logic       clk     = 1'b0;
    logic       reset   = 1'b1;
    logic       s_valid = 1'b0;
    logic [7:0] s_data  = 8'h00;
    logic       s_ready;
    logic       h_write;
    logic [3:0] h_index;
    logic [7:0] h_value;
    logic       busy;
    logic       done;
    logic       error;

    always #5 clk = ~clk;

    conv_coef_loader #(
        .KERNEL_SIZE (KS),
        .SYNC_BYTE   (8'hA5)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .s_valid (s_valid),
        .s_ready (s_ready),
        .s_data  (s_data),
        .h_write (h_write),
        .h_index (h_index),
        .h_value (h_value),
        .busy    (busy),
        .done    (done),
        .error   (error)
    );

    // ---------------- model state ----------------
    typedef struct {
        int         at;
        logic [3:0] idx;
        logic [7:0] val;
    } wr_t;

    wr_t        wq[$];
    logic [7:0] m_frame[$];
    int         cyc        = 0;
    int         m_phase    = 0;   // 0 idle, 1 expect count, 2 data, 3 checksum
    int         m_n        = 0;
    int         m_lo       = 1;
    int         m_hi       = 0;
    int         m_done_at  = -1;
    logic       m_err      = 1'b0;
    logic       m_clk_seen = 1'b0;

    // ---------------- scoreboard ----------------
    int n_checks = 0;
    int n_fail   = 0;
    int probe_seq = 0, probe_ack = 0, probe_kind = 0, probe_val = 0;
    logic [7:0] obs_v[$];
    logic [3:0] obs_i[$];
    int fidx = 0;

    localparam int         LIT_LEN [6]    = '{3, 1, 1, 3, 2, 3};
    localparam logic [7:0] LIT_VAL [6][3] = '{
        '{8'h05, 8'hFE, 8'h07},
        '{8'h7F, 8'h00, 8'h00},
        '{8'h7F, 8'h00, 8'h00},
        '{8'h05, 8'hFE, 8'h07},
        '{8'h80, 8'h81, 8'h00},
        '{8'h01, 8'h02, 8'h03}
    };

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s cyc=%0d actual=%0h required=%0h", nm, cyc, act, exp);
        end
    endtask

    // Frame-level model: consumes each transferred byte.
    initial begin : model_p
        logic [7:0] sum;
        forever begin
            @(posedge clk or negedge reset);
            if (!reset) begin
                m_phase    = 0;
                m_frame.delete();
                wq.delete();
                m_lo       = 1;
                m_hi       = 0;
                m_done_at  = -1;
                m_err      = 1'b0;
                m_clk_seen = 1'b0;
            end else begin
                cyc++;
                if (s_valid && s_ready) begin
                    case (m_phase)
                        0: if (s_data == 8'hA5) begin
                            m_phase = 1;
                            m_err   = 1'b0;
                        end
                        1: if (s_data >= 8'd1 && s_data <= 8'(KS)) begin
                            m_n = int'(s_data);
                            m_frame.delete();
                            m_phase = 2;
                        end else begin
                            m_err   = 1'b1;
                            m_phase = 0;
                        end
                        2: begin
                            m_frame.push_back(s_data);
                            if (m_frame.size() == m_n) m_phase = 3;
                        end
                        default: begin
                            sum = 8'h00;
                            foreach (m_frame[i]) sum = sum + m_frame[i];
                            if (sum == s_data) begin
                                for (int k = 0; k < m_n; k++)
                                    wq.push_back('{cyc + k, 4'(k), m_frame[k]});
                                m_lo      = cyc;
                                m_hi      = cyc + m_n - 1;
                                m_done_at = cyc + m_n;
                            end else begin
                                m_err = 1'b1;
                            end
                            m_phase = 0;
                        end
                    endcase
                end
                m_clk_seen = 1'b1;
            end
        end
    end

    // Compare process: every falling edge.
    initial begin : cmp_p
        logic       exp_w;
        logic [3:0] ei;
        logic [7:0] ev;
        logic       in_commit;
        forever begin
            @(negedge clk);
            if (!reset) begin
                chk("rst_h_write", h_write, 0);
                chk("rst_h_index", h_index, 0);
                chk("rst_h_value", h_value, 0);
                chk("rst_busy",    busy,    0);
                chk("rst_done",    done,    0);
                chk("rst_error",   error,   0);
                chk("rst_s_ready", s_ready, 0);
                obs_v.delete();
                obs_i.delete();
            end else begin
                exp_w = 1'b0; ei = 4'd0; ev = 8'h00;
                foreach (wq[i]) if (wq[i].at == cyc) begin
                    exp_w = 1'b1; ei = wq[i].idx; ev = wq[i].val;
                end
                in_commit = (cyc >= m_lo) && (cyc <= m_hi);
                chk("h_write", h_write, exp_w);
                if (exp_w && h_write) begin
                    chk("h_index", h_index, ei);
                    chk("h_value", h_value, ev);
                end
                chk("done",    done,    cyc == m_done_at);
                chk("error",   error,   m_err);
                chk("s_ready", s_ready, m_clk_seen && !in_commit);
                chk("busy",    busy,    (m_phase != 0) || in_commit);
                if (h_write) begin
                    obs_v.push_back(h_value);
                    obs_i.push_back(h_index);
                end
                if (done) begin
                    if (fidx < 6) begin
                        chk("lit_len", obs_v.size(), LIT_LEN[fidx]);
                        for (int i = 0; i < obs_v.size() && i < LIT_LEN[fidx]; i++) begin
                            chk("lit_idx", obs_i[i], i);
                            chk("lit_val", obs_v[i], LIT_VAL[fidx][i]);
                        end
                    end else begin
                        chk("lit_extra_frame", fidx, 5);
                    end
                    fidx++;
                    obs_v.delete();
                    obs_i.delete();
                end
            end
            if (probe_seq != probe_ack) begin
                probe_ack = probe_seq;
                if (probe_kind == 0) chk("probe_error", error, probe_val);
                else                 chk("probe_frames", fidx, probe_val);
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic send(input logic [7:0] b);
        logic acc;
        acc = 1'b0;
        s_valid = 1'b1;
        s_data  = b;
        for (int i = 0; i < 50 && !acc; i++) begin
            acc = s_ready;
            @(negedge clk);
        end
        s_valid = 1'b0;
        if (!acc) begin
            $display("FAIL send_timeout byte=%0h", b);
            $fatal(1, "handshake timeout");
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic probe(input int kind, input int val);
        probe_kind = kind;
        probe_val  = val;
        probe_seq++;
        idle(2);
    endtask

    task automatic pulse_reset();
        #2 reset = 1'b0;
        idle(2);
        #2 reset = 1'b1;
        idle(2);
    endtask

    initial begin
        #1 reset = 1'b0;
        idle(3);
        #2 reset = 1'b1;
        idle(3);

        // Valid frame
        send(8'hA5); send(8'h03); send(8'h05); send(8'hFE); send(8'h07); send(8'h0A);
        idle(6);
        probe(0, 0);

        // Bad checksum
        send(8'hA5); send(8'h03); send(8'h05); send(8'hFE); send(8'h07); send(8'h0B);
        probe(0, 1);
        idle(2);

        // Illegal count 4, then recovery frame
        send(8'hA5); send(8'h04);
        probe(0, 1);
        send(8'hA5); send(8'h01); send(8'h7F); send(8'h7F);
        idle(4);
        probe(0, 0);

        // Illegal count 0, then recovery frame
        send(8'hA5); send(8'h00);
        probe(0, 1);
        send(8'hA5); send(8'h01); send(8'h7F); send(8'h7F);
        idle(4);

        // Garbage then valid frame with a valid gap
        send(8'h00); send(8'h12); send(8'hFF);
        send(8'hA5); send(8'h03); send(8'h05);
        idle(2);
        send(8'hFE); send(8'h07); send(8'h0A);
        idle(6);

        // Reset after the second coefficient byte
        send(8'hA5); send(8'h03); send(8'h05); send(8'hFE);
        pulse_reset();
        send(8'hA5); send(8'h02); send(8'h80); send(8'h81); send(8'h01);
        idle(5);

        // Reset during the second commit write
        send(8'hA5); send(8'h03); send(8'h05); send(8'hFE); send(8'h07); send(8'h0A);
        idle(1);
        pulse_reset();
        send(8'hA5); send(8'h03); send(8'h01); send(8'h02); send(8'h03); send(8'h06);
        idle(6);

        probe(1, 6);
        idle(2);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
